ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Consumer end of the ALU interface: registers the ALU result and zero flag into the EX/MEM pipeline boundary of the RV32I pipelined core.
- Resolves conditional branches and jumps from the ALU outputs, issues a one-cycle fetch redirect, and squashes the wrong-path instructions that follow a taken branch or jump.
- Sits between the execute stage (ALU, operand mux) and the data-memory stage, with a valid/ready handshake on both sides.

Parameters:
- KILL_SLOTS, 2, number of accepted EX beats squashed after a taken branch or jump (wrong-path depth of IF/ID); legal range 1..7.
- XLEN, 32, datapath width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- ex_valid  input  1  EX stage presents an instruction
- ex_ready  output  1  stage can accept this cycle
- alu_result  input  XLEN  ALU result
- alu_zero  input  1  ALU zero flag
- ex_funct3  input  3  branch condition select
- ex_branch  input  1  conditional branch
- ex_jump  input  1  jal/jalr
- ex_regwrite  input  1  register-file write enable
- ex_memwrite  input  1  data-memory write enable
- ex_resultsrc  input  2  writeback select
- ex_writedata  input  XLEN  store data
- ex_rd  input  5  destination register
- ex_pcplus4  input  XLEN  PC+4
- ex_pctarget  input  XLEN  branch/jump target
- mem_valid  output  1  MEM-side register holds a live instruction
- mem_ready  input  1  MEM stage accepts
- mem_aluresult  output  XLEN  registered ALU result
- mem_writedata  output  XLEN  registered store data
- mem_rd  output  5  registered rd
- mem_regwrite  output  1  registered regwrite
- mem_memwrite  output  1  registered memwrite
- mem_resultsrc  output  2  registered resultsrc
- mem_pcplus4  output  XLEN  registered PC+4
- redirect_valid  output  1  one-cycle fetch redirect pulse
- redirect_pc  output  XLEN  redirect target

Behaviour:
- Reset: synchronous, active-high, on clk rising edge. Every output register and the kill counter are cleared to 0; the state returns to RUN. Reset mid-stall or mid-kill discards everything.
- Handshake:
  - ex_ready = !mem_valid || mem_ready (combinational).
  - An EX beat is accepted when ex_valid && ex_ready.
  - When mem_valid && !mem_ready, all mem_* registers hold.
  - If mem_ready is high and no beat is accepted, mem_valid drops to 0 next cycle.
- Branch condition on ex_funct3 (the ALU computes sub for beq/bne and slt for blt/bge):
  - 000: taken = alu_zero
  - 001: taken = !alu_zero
  - 100: taken = alu_result[0]
  - 101: taken = !alu_result[0]
  - All other values: not taken (bltu/bgeu unsupported).
  - Overall: taken = ex_jump || (ex_branch && cond).
- States:
  - RUN: an accepted beat is registered to mem_* with mem_valid=1 the next cycle. Latency is 1 cycle. If the beat is taken, then next cycle redirect_valid=1 for exactly one cycle, redirect_pc=ex_pctarget, kill counter is loaded with KILL_SLOTS, and the state goes to KILL.
  - KILL: each accepted beat is squashed and the counter decrements. Squashed means mem_* is not loaded, mem_valid=0 if the downstream drained, and no side effects. When the counter reaches 0 the state returns to RUN.
- Kill counting: ex_valid=0 cycles and stalled cycles do not decrement the counter; only accepted beats are counted.
- Jumps: the jump instruction itself is registered normally with mem_resultsrc as provided, so PC+4 writeback is carried.
- Squashed beats never produce a redirect, so a second taken branch inside the kill window is ignored.
- redirect_valid is independent of mem_ready: it fires on acceptance, not on drain.
- No arithmetic beyond the 1-bit compare; the counter is 3 bits wide.

Decomposition:
- Shared package core_pkg:
  - funct3 branch constants: F3_BEQ, F3_BNE, F3_BLT, F3_BGE.
  - resultsrc encodings.
  - State encodings RUN/KILL.
- One sub-module, branch_cond: a combinational funct3/zero/result[0] to taken evaluator, reused by later forwarding-aware branch logic.
- Registers and the FSM live in ex_mem_stage.

Test Plan:
- Plain flow: ALU add result 0x0000_0010, rd=5, regwrite=1, mem_ready=1 -> the next cycle shows mem_valid=1, mem_aluresult=0x10, mem_rd=5, and no redirect.
- beq taken: branch=1, funct3=000, alu_zero=1, pctarget=0x40, followed by 3 valid beats -> redirect_valid pulses once with redirect_pc=0x40; beats 2 and 3 are squashed (mem_valid=0); beat 4 is registered.
- bne not taken (alu_zero=1) and blt taken (alu_result=1) -> no redirect for bne, redirect for blt; funct3=110 with result=1 -> no redirect.
- Stall: mem_ready=0 for 3 cycles with mem_valid=1 -> ex_ready=0, mem_* stable; when mem_ready=1 the next beat loads in the following cycle.
- Kill window with bubbles: jal taken, then ex_valid=0 for 2 cycles, then 3 beats -> only the first 2 of those beats are squashed; the counter does not decrement during the bubbles.
- Reset asserted one cycle into KILL -> all outputs are 0 the next cycle, and the first post-reset beat is registered, not squashed.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the RV32I pipelined core.
package core_pkg;

  // Branch condition selects carried in funct3.
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  // Writeback select encodings.
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // EX/MEM boundary control state.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_KILL = 1'b1
  } exmem_state_e;

endpackage

// File: rtl/ex_mem_stage_branch_cond.sv
// Combinational branch/jump resolution from ALU outputs.
// blt/bge rely on the ALU having computed slt, so bit 0 is the compare.
module branch_cond
  import core_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       alu_zero_i,
  input  logic       alu_lsb_i,
  input  logic       branch_i,
  input  logic       jump_i,
  output logic       taken_o
);

  logic cond;

  // Condition select; bltu/bgeu and reserved codes never take.
  always_comb begin
    cond = 1'b0;
    case (funct3_i)
      F3_BEQ:  cond = alu_zero_i;
      F3_BNE:  cond = !alu_zero_i;
      F3_BLT:  cond = alu_lsb_i;
      F3_BGE:  cond = !alu_lsb_i;
      default: cond = 1'b0;
    endcase
  end

  assign taken_o = jump_i || (branch_i && cond);

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution, fetch redirect and
// wrong-path squash of the next KILL_SLOTS accepted beats.
module ex_mem_stage
  import core_pkg::*;
#(
  parameter int KILL_SLOTS = 2,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic            ex_regwrite,
  input  logic            ex_memwrite,
  input  logic [1:0]      ex_resultsrc,
  input  logic [XLEN-1:0] ex_writedata,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_pcplus4,
  input  logic [XLEN-1:0] ex_pctarget,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_aluresult,
  output logic [XLEN-1:0] mem_writedata,
  output logic [4:0]      mem_rd,
  output logic            mem_regwrite,
  output logic            mem_memwrite,
  output logic [1:0]      mem_resultsrc,
  output logic [XLEN-1:0] mem_pcplus4,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [2:0] KILL_INIT = 3'(KILL_SLOTS);

  exmem_state_e    state_q, state_d;
  logic [2:0]      kill_cnt_q, kill_cnt_d;
  logic            mem_valid_q, mem_valid_d;
  logic [XLEN-1:0] aluresult_q, aluresult_d;
  logic [XLEN-1:0] writedata_q, writedata_d;
  logic [4:0]      rd_q, rd_d;
  logic            regwrite_q, regwrite_d;
  logic            memwrite_q, memwrite_d;
  logic [1:0]      resultsrc_q, resultsrc_d;
  logic [XLEN-1:0] pcplus4_q, pcplus4_d;
  logic            redir_vld_q, redir_vld_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;

  logic taken;
  logic accept;

  branch_cond u_branch_cond (
    .funct3_i   (ex_funct3),
    .alu_zero_i (alu_zero),
    .alu_lsb_i  (alu_result[0]),
    .branch_i   (ex_branch),
    .jump_i     (ex_jump),
    .taken_o    (taken)
  );

  assign ex_ready = !mem_valid_q || mem_ready;
  assign accept   = ex_valid && ex_ready;

  // Next-state: load, squash or drain the boundary register; arm the kill window.
  always_comb begin
    state_d     = state_q;
    kill_cnt_d  = kill_cnt_q;
    mem_valid_d = mem_valid_q;
    aluresult_d = aluresult_q;
    writedata_d = writedata_q;
    rd_d        = rd_q;
    regwrite_d  = regwrite_q;
    memwrite_d  = memwrite_q;
    resultsrc_d = resultsrc_q;
    pcplus4_d   = pcplus4_q;
    redir_vld_d = 1'b0;
    redir_pc_d  = redir_pc_q;

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          mem_valid_d = 1'b1;
          aluresult_d = alu_result;
          writedata_d = ex_writedata;
          rd_d        = ex_rd;
          regwrite_d  = ex_regwrite;
          memwrite_d  = ex_memwrite;
          resultsrc_d = ex_resultsrc;
          pcplus4_d   = ex_pcplus4;
          if (taken) begin
            redir_vld_d = 1'b1;
            redir_pc_d  = ex_pctarget;
            kill_cnt_d  = KILL_INIT;
            state_d     = ST_KILL;
          end
        end else if (mem_ready) begin
          mem_valid_d = 1'b0;
        end
      end
      ST_KILL: begin
        // A squashed beat still frees the register if downstream drained.
        if (accept) begin
          mem_valid_d = 1'b0;
          kill_cnt_d  = kill_cnt_q - 3'd1;
          if (kill_cnt_q == 3'd1) state_d = ST_RUN;
        end else if (mem_ready) begin
          mem_valid_d = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and boundary registers; reset discards any stall or kill in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      kill_cnt_q  <= '0;
      mem_valid_q <= 1'b0;
      aluresult_q <= '0;
      writedata_q <= '0;
      rd_q        <= '0;
      regwrite_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      resultsrc_q <= '0;
      pcplus4_q   <= '0;
      redir_vld_q <= 1'b0;
      redir_pc_q  <= '0;
    end else begin
      state_q     <= state_d;
      kill_cnt_q  <= kill_cnt_d;
      mem_valid_q <= mem_valid_d;
      aluresult_q <= aluresult_d;
      writedata_q <= writedata_d;
      rd_q        <= rd_d;
      regwrite_q  <= regwrite_d;
      memwrite_q  <= memwrite_d;
      resultsrc_q <= resultsrc_d;
      pcplus4_q   <= pcplus4_d;
      redir_vld_q <= redir_vld_d;
      redir_pc_q  <= redir_pc_d;
    end
  end

  assign mem_valid      = mem_valid_q;
  assign mem_aluresult  = aluresult_q;
  assign mem_writedata  = writedata_q;
  assign mem_rd         = rd_q;
  assign mem_regwrite   = regwrite_q;
  assign mem_memwrite   = memwrite_q;
  assign mem_resultsrc  = resultsrc_q;
  assign mem_pcplus4    = pcplus4_q;
  assign redirect_valid = redir_vld_q;
  assign redirect_pc    = redir_pc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage (KILL_SLOTS=2).
module tb_ex_mem_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ready;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [2:0]  ex_funct3;
  logic        ex_branch, ex_jump, ex_regwrite, ex_memwrite;
  logic [1:0]  ex_resultsrc;
  logic [31:0] ex_writedata, ex_pcplus4, ex_pctarget;
  logic [4:0]  ex_rd;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_aluresult, mem_writedata, mem_pcplus4;
  logic [4:0]  mem_rd;
  logic        mem_regwrite, mem_memwrite;
  logic [1:0]  mem_resultsrc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_chk = 0;
  int n_err = 0;

  ex_mem_stage #(.KILL_SLOTS(2), .XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_result(alu_result), .alu_zero(alu_zero), .ex_funct3(ex_funct3),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_regwrite(ex_regwrite),
    .ex_memwrite(ex_memwrite), .ex_resultsrc(ex_resultsrc),
    .ex_writedata(ex_writedata), .ex_rd(ex_rd), .ex_pcplus4(ex_pcplus4),
    .ex_pctarget(ex_pctarget),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_aluresult(mem_aluresult), .mem_writedata(mem_writedata),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memwrite(mem_memwrite),
    .mem_resultsrc(mem_resultsrc), .mem_pcplus4(mem_pcplus4),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Plain ALU op, valid, all control off.
  task automatic set_alu(input logic [31:0] res, input logic [4:0] rd);
    ex_valid = 1'b1; alu_result = res; alu_zero = (res == 32'd0);
    ex_funct3 = 3'b000; ex_branch = 1'b0; ex_jump = 1'b0;
    ex_regwrite = 1'b1; ex_memwrite = 1'b0; ex_resultsrc = RES_ALU;
    ex_writedata = 32'hDEAD_0000 | res; ex_rd = rd;
    ex_pcplus4 = 32'h1000 + res; ex_pctarget = 32'h0;
  endtask

  task automatic set_br(input logic [2:0] f3, input logic z,
                        input logic [31:0] res, input logic [31:0] tgt);
    set_alu(res, 5'd0);
    alu_zero = z; ex_funct3 = f3; ex_branch = 1'b1;
    ex_regwrite = 1'b0; ex_pctarget = tgt;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1;
    set_alu(32'h0, 5'd0); ex_valid = 1'b0;
    step; step;
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_redirect",  32'(redirect_valid), 32'd0);
    chk("rst_aluresult", mem_aluresult, 32'd0);
    reset = 1'b0;
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);

    // plain flow
    set_alu(32'h10, 5'd5); step;
    chk("plain_valid", 32'(mem_valid), 32'd1);
    chk("plain_alu",   mem_aluresult, 32'h10);
    chk("plain_rd",    32'(mem_rd), 32'd5);
    chk("plain_rw",    32'(mem_regwrite), 32'd1);
    chk("plain_redir", 32'(redirect_valid), 32'd0);

    // beq taken, then 3 beats: 2 squashed, 3rd registered
    set_br(F3_BEQ, 1'b1, 32'h0, 32'h40); step;
    chk("beq_valid",     32'(mem_valid), 32'd1);
    chk("beq_redir",     32'(redirect_valid), 32'd1);
    chk("beq_redir_pc",  redirect_pc, 32'h40);
    set_alu(32'h100, 5'd1); step;
    chk("beq_sq1_valid", 32'(mem_valid), 32'd0);
    chk("beq_pulse_end", 32'(redirect_valid), 32'd0);
    set_br(F3_BEQ, 1'b1, 32'h0, 32'h99); step;   // taken branch inside window
    chk("beq_sq2_valid", 32'(mem_valid), 32'd0);
    chk("beq_sq2_redir", 32'(redirect_valid), 32'd0);
    set_alu(32'h300, 5'd3); step;
    chk("beq_b4_valid",  32'(mem_valid), 32'd1);
    chk("beq_b4_alu",    mem_aluresult, 32'h300);
    chk("beq_b4_redir",  32'(redirect_valid), 32'd0);

    // beq not taken, bne not taken
    set_br(F3_BEQ, 1'b0, 32'h4, 32'h50); step;
    chk("beq_nt_redir", 32'(redirect_valid), 32'd0);
    set_br(F3_BNE, 1'b1, 32'h0, 32'h50); step;
    chk("bne_nt_redir", 32'(redirect_valid), 32'd0);
    chk("bne_nt_valid", 32'(mem_valid), 32'd1);

    // blt taken, drain window with 2 beats
    set_br(F3_BLT, 1'b0, 32'h1, 32'h60); step;
    chk("blt_redir",    32'(redirect_valid), 32'd1);
    chk("blt_redir_pc", redirect_pc, 32'h60);
    set_alu(32'h7, 5'd7); step;
    set_alu(32'h8, 5'd8); step;
    chk("blt_sq2_valid", 32'(mem_valid), 32'd0);

    // funct3=110 unsupported -> registered, no redirect
    set_br(3'b110, 1'b0, 32'h1, 32'h70); step;
    chk("f110_redir", 32'(redirect_valid), 32'd0);
    chk("f110_valid", 32'(mem_valid), 32'd1);
    chk("f110_alu",   mem_aluresult, 32'h1);

    // stall
    set_alu(32'h55, 5'd9); step;
    chk("stall_pre_alu", mem_aluresult, 32'h55);
    mem_ready = 1'b0; set_alu(32'h66, 5'd10); #1;
    chk("stall_ready0", 32'(ex_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("stall_alu_hold", mem_aluresult, 32'h55);
      chk("stall_valid",    32'(mem_valid), 32'd1);
      chk("stall_ready",    32'(ex_ready), 32'd0);
    end
    mem_ready = 1'b1; #1;
    chk("stall_ready1", 32'(ex_ready), 32'd1);
    step;
    chk("stall_load_alu", mem_aluresult, 32'h66);
    chk("stall_load_rd",  32'(mem_rd), 32'd10);

    // jal, 2 bubbles, 3 beats
    set_alu(32'h84, 5'd1); ex_jump = 1'b1; ex_resultsrc = RES_PC4;
    ex_pcplus4 = 32'h80; ex_pctarget = 32'h200; step;
    chk("jal_valid",    32'(mem_valid), 32'd1);
    chk("jal_rsrc",     32'(mem_resultsrc), 32'(RES_PC4));
    chk("jal_pc4",      mem_pcplus4, 32'h80);
    chk("jal_redir",    32'(redirect_valid), 32'd1);
    chk("jal_redir_pc", redirect_pc, 32'h200);
    ex_valid = 1'b0; ex_jump = 1'b0; step;
    chk("jal_bub_valid", 32'(mem_valid), 32'd0);
    chk("jal_bub_redir", 32'(redirect_valid), 32'd0);
    step;
    set_alu(32'hA1, 5'd11); step;
    chk("jal_sq1", 32'(mem_valid), 32'd0);
    set_alu(32'hA2, 5'd12); step;
    chk("jal_sq2", 32'(mem_valid), 32'd0);
    set_alu(32'hA3, 5'd13); step;
    chk("jal_b3_valid", 32'(mem_valid), 32'd1);
    chk("jal_b3_alu",   mem_aluresult, 32'hA3);

    // reset one cycle into KILL
    set_alu(32'hB0, 5'd2); ex_jump = 1'b1; ex_pctarget = 32'h300; step;
    chk("rk_redir", 32'(redirect_valid), 32'd1);
    reset = 1'b1; set_alu(32'hB1, 5'd3); step;
    chk("rk_valid", 32'(mem_valid), 32'd0);
    chk("rk_alu",   mem_aluresult, 32'd0);
    chk("rk_redir0", 32'(redirect_valid), 32'd0);
    chk("rk_rpc",   redirect_pc, 32'd0);
    chk("rk_pc4",   mem_pcplus4, 32'd0);
    reset = 1'b0; set_alu(32'h777, 5'd4); step;
    chk("rk_post_valid", 32'(mem_valid), 32'd1);
    chk("rk_post_alu",   mem_aluresult, 32'h777);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
